// File: rtl/coin_credit_fsm.sv
// Coin-acceptance and vend-sequencing controller: accumulates credit in nickels,
// pulses dispense at the price, then returns change or refunds one nickel per cycle.
module coin_credit_fsm #(
  parameter int unsigned PRICE = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  output logic [4:0] credit,
  output logic       dispense,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StVend,
    StChange,
    StRefund
  } state_e;

  localparam logic [5:0] PriceW = 6'(PRICE);

  state_e     state_q, state_d;
  logic [4:0] credit_q, credit_d;
  logic       reject_q, reject_d;

  logic [2:0] coin_value;
  logic [5:0] sum;

  always_comb begin
    coin_value = 3'd0;
    unique case (coin_type)
      2'b01:   coin_value = 3'd1;
      2'b10:   coin_value = 3'd2;
      2'b11:   coin_value = 3'd5;
      default: coin_value = 3'd0;
    endcase
  end

  assign sum = {1'b0, credit_q} + {3'b000, coin_value};

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    unique case (state_q)
      StIdle, StAccum: begin
        if (cancel && (state_q == StAccum)) begin
          // Cancel wins over a simultaneous coin; that coin is handed back.
          state_d  = StRefund;
          reject_d = coin_valid;
        end else if (coin_valid) begin
          if (coin_type == 2'b00) begin
            reject_d = 1'b1;
          end else if (sum >= PriceW) begin
            state_d  = StVend;
            credit_d = 5'(sum - PriceW);
          end else begin
            state_d  = StAccum;
            credit_d = sum[4:0];
          end
        end
      end
      StVend: begin
        reject_d = coin_valid;
        state_d  = (credit_q != 5'd0) ? StChange : StIdle;
      end
      StChange, StRefund: begin
        reject_d = coin_valid;
        if (credit_q <= 5'd1) begin
          state_d  = StIdle;
          credit_d = 5'd0;
        end else begin
          credit_d = credit_q - 5'd1;
        end
      end
      default: begin
        state_d  = StIdle;
        credit_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      credit_q <= 5'd0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  assign credit       = credit_q;
  assign dispense     = (state_q == StVend);
  assign change_pulse = (state_q == StChange) || (state_q == StRefund);
  assign busy         = (state_q == StVend) || change_pulse;
  assign coin_reject  = reject_q;

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Directed scoreboard bench for coin_credit_fsm (PRICE = 5): each step pushes the
// expected outputs of the following cycle and compares them after the edge.
module tb_coin_credit_fsm;

  logic       clk = 1'b0;
  logic       reset, coin_valid, cancel;
  logic [1:0] coin_type;
  logic [4:0] credit;
  logic       dispense, change_pulse, coin_reject, busy;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [4:0] credit;
    logic       dispense;
    logic       change_pulse;
    logic       coin_reject;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  coin_credit_fsm #(.PRICE(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .cancel       (cancel),
    .credit       (credit),
    .dispense     (dispense),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs; expected values describe the cycle after the edge.
  task automatic step(input string tag, input logic rst, input logic cv, input logic [1:0] ct,
                      input logic cn, input logic [4:0] e_cr, input logic e_d, input logic e_c,
                      input logic e_r, input logic e_b);
    exp_t e;
    reset      = rst;
    coin_valid = cv;
    coin_type  = ct;
    cancel     = cn;
    e.credit       = e_cr;
    e.dispense     = e_d;
    e.change_pulse = e_c;
    e.coin_reject  = e_r;
    e.busy         = e_b;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check({tag, ".credit"}, credit, e.credit);
    check({tag, ".dispense"}, {4'd0, dispense}, {4'd0, e.dispense});
    check({tag, ".change_pulse"}, {4'd0, change_pulse}, {4'd0, e.change_pulse});
    check({tag, ".coin_reject"}, {4'd0, coin_reject}, {4'd0, e.coin_reject});
    check({tag, ".busy"}, {4'd0, busy}, {4'd0, e.busy});
  endtask

  localparam logic [1:0] Slug = 2'b00, Nick = 2'b01, Dime = 2'b10, Quar = 2'b11;

  initial begin
    reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; cancel = 1'b0;
    @(negedge clk);
    //            tag        rst cv ct    cn  cr    d  c  r  b
    step("reset",    1, 0, Slug, 0, 5'd0, 0, 0, 0, 0);
    // Exact-price quarter
    step("q_vend",   0, 1, Quar, 0, 5'd0, 1, 0, 0, 1);
    step("q_idle",   0, 0, Slug, 0, 5'd0, 0, 0, 0, 0);
    // Nickel, dime, dime
    step("ndd_n",    0, 1, Nick, 0, 5'd1, 0, 0, 0, 0);
    step("ndd_d1",   0, 1, Dime, 0, 5'd3, 0, 0, 0, 0);
    step("ndd_vend", 0, 1, Dime, 0, 5'd0, 1, 0, 0, 1);
    step("ndd_idle", 0, 0, Slug, 0, 5'd0, 0, 0, 0, 0);
    // Dime, dime, quarter: 4 nickels change
    step("ddq_d1",   0, 1, Dime, 0, 5'd2, 0, 0, 0, 0);
    step("ddq_d2",   0, 1, Dime, 0, 5'd4, 0, 0, 0, 0);
    step("ddq_vend", 0, 1, Quar, 0, 5'd4, 1, 0, 0, 1);
    step("ddq_c4",   0, 0, Slug, 0, 5'd4, 0, 1, 0, 1);
    step("ddq_c3",   0, 0, Slug, 0, 5'd3, 0, 1, 0, 1);
    step("ddq_c2",   0, 0, Slug, 0, 5'd2, 0, 1, 0, 1);
    step("ddq_c1",   0, 0, Slug, 0, 5'd1, 0, 1, 0, 1);
    step("ddq_idle", 0, 0, Slug, 0, 5'd0, 0, 0, 0, 0);
    // Dime, then cancel with a nickel: cancel wins
    step("cx_d",     0, 1, Dime, 0, 5'd2, 0, 0, 0, 0);
    step("cx_ref2",  0, 1, Nick, 1, 5'd2, 0, 1, 1, 1);
    step("cx_ref1",  0, 0, Slug, 0, 5'd1, 0, 1, 0, 1);
    step("cx_idle",  0, 0, Slug, 0, 5'd0, 0, 0, 0, 0);
    // Slug in IDLE, then a quarter during change
    step("slug",     0, 1, Slug, 0, 5'd0, 0, 0, 1, 0);
    step("sq_d1",    0, 1, Dime, 0, 5'd2, 0, 0, 0, 0);
    step("sq_d2",    0, 1, Dime, 0, 5'd4, 0, 0, 0, 0);
    step("sq_vend",  0, 1, Quar, 0, 5'd4, 1, 0, 0, 1);
    step("sq_c4",    0, 0, Slug, 0, 5'd4, 0, 1, 0, 1);
    step("sq_c3q",   0, 1, Quar, 0, 5'd3, 0, 1, 1, 1);
    step("sq_c2",    0, 0, Slug, 0, 5'd2, 0, 1, 0, 1);
    step("sq_c1",    0, 0, Slug, 0, 5'd1, 0, 1, 0, 1);
    step("sq_idle",  0, 0, Slug, 0, 5'd0, 0, 0, 0, 0);
    // Reset during the second of four change pulses
    step("rs_d1",    0, 1, Dime, 0, 5'd2, 0, 0, 0, 0);
    step("rs_d2",    0, 1, Dime, 0, 5'd4, 0, 0, 0, 0);
    step("rs_vend",  0, 1, Quar, 0, 5'd4, 1, 0, 0, 1);
    step("rs_c4",    0, 0, Slug, 0, 5'd4, 0, 1, 0, 1);
    step("rs_c3",    0, 0, Slug, 0, 5'd3, 0, 1, 0, 1);
    step("rs_reset", 1, 0, Slug, 0, 5'd0, 0, 0, 0, 0);
    step("rs_quiet", 0, 0, Slug, 0, 5'd0, 0, 0, 0, 0);
    step("rs_qvend", 0, 1, Quar, 0, 5'd0, 1, 0, 0, 1);
    step("rs_qidle", 0, 0, Slug, 0, 5'd0, 0, 0, 0, 0);
    // Cancel with a coin in IDLE is ignored; cancel alone in ACCUM refunds
    step("ic_n",     0, 1, Nick, 1, 5'd1, 0, 0, 0, 0);
    step("ic_ref",   0, 0, Slug, 1, 5'd1, 0, 1, 0, 1);
    step("ic_idle",  0, 0, Slug, 0, 5'd0, 0, 0, 0, 0);
    step("ic_cidle", 0, 0, Slug, 1, 5'd0, 0, 0, 0, 0);
    // Coin during VEND is rejected
    step("vc_vend",  0, 1, Quar, 0, 5'd0, 1, 0, 0, 1);
    step("vc_rej",   0, 1, Nick, 0, 5'd0, 0, 0, 1, 0);
    // Overshoot by one: single change nickel
    step("ov_n",     0, 1, Nick, 0, 5'd1, 0, 0, 0, 0);
    step("ov_vend",  0, 1, Quar, 0, 5'd1, 1, 0, 0, 1);
    step("ov_c1",    0, 0, Slug, 0, 5'd1, 0, 1, 0, 1);
    step("ov_idle",  0, 0, Slug, 0, 5'd0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
